// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared widths, fetch byte-select constant and arbiter FSM encoding
package bus_arbiter_pkg;
  localparam int REG_BUS = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam logic [3:0] ARB_SEL_ALL = 4'b1111;
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_RESP_I = 3'd3,
    ARB_RESP_D = 3'd4
  } arb_state_e;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: 8-bit watchdog counter; expired_o flags the LIMIT-th enabled cycle
module arb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over count
  always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  assign expired_o = en_i && (cnt_q == 8'(LIMIT - 1));
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between fetch and data ports; define STPU_ARB_RR_EN for round-robin grant
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_i,
  input  logic [INST_ADDR_BUS-1:0] if_addr_i,
  output logic [REG_BUS-1:0]       if_rdata_o,
  output logic                     if_ack_o,
  input  logic                     mem_req_i,
  input  logic                     mem_we_i,
  input  logic [REG_BUS-1:0]       mem_addr_i,
  input  logic [3:0]               mem_sel_i,
  input  logic [REG_BUS-1:0]       mem_wdata_i,
  output logic [REG_BUS-1:0]       mem_rdata_o,
  output logic                     mem_ack_o,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [REG_BUS-1:0]       bus_addr_o,
  output logic [3:0]               bus_sel_o,
  output logic [REG_BUS-1:0]       bus_wdata_o,
  input  logic [REG_BUS-1:0]       bus_rdata_i,
  input  logic                     bus_ack_i,
  output logic                     bus_err_o,
  output logic                     stallreq_if_o,
  output logic                     stallreq_mem_o
);
  arb_state_e state_q, state_d;
  logic if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, err_q, err_d, to_q, to_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [3:0] bus_sel_q, bus_sel_d;
  logic [REG_BUS-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [REG_BUS-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic grant_mem, busy, expired;
`ifdef STPU_ARB_RR_EN
  logic last_q, last_d;
  assign grant_mem = mem_req_i && (!if_req_i || !last_q);
`else
  assign grant_mem = mem_req_i;
`endif
  assign busy = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  arb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .en_i      (busy),
    .expired_o (expired)
  );
  // next-state and registered-output computation; a new grant waits until the previous ack pulse is gone
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    to_d        = to_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
`ifdef STPU_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ARB_IDLE:
        if (!if_ack_q && !mem_ack_q && (if_req_i || mem_req_i)) begin
          state_d     = grant_mem ? ARB_BUSY_D : ARB_BUSY_I;
          bus_req_d   = 1'b1;
          bus_we_d    = grant_mem && mem_we_i;
          bus_addr_d  = grant_mem ? mem_addr_i : if_addr_i;
          bus_sel_d   = grant_mem ? mem_sel_i : ARB_SEL_ALL;
          bus_wdata_d = grant_mem ? mem_wdata_i : '0;
        end
      ARB_BUSY_I, ARB_BUSY_D:
        if (bus_ack_i || expired) begin
          state_d   = (state_q == ARB_BUSY_D) ? ARB_RESP_D : ARB_RESP_I;
          bus_req_d = 1'b0;
          to_d      = !bus_ack_i;
          if (state_q == ARB_BUSY_D) mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          else                       if_rdata_d  = bus_ack_i ? bus_rdata_i : '0;
`ifdef STPU_ARB_RR_EN
          last_d = (state_q == ARB_BUSY_D);
`endif
        end
      ARB_RESP_I, ARB_RESP_D: begin
        state_d   = ARB_IDLE;
        if_ack_d  = (state_q == ARB_RESP_I);
        mem_ack_d = (state_q == ARB_RESP_D);
        err_d     = to_q;
        to_d      = 1'b0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      to_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      to_q        <= to_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
`ifdef STPU_ARB_RR_EN
  // port served last; starts as fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
`endif
  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_sel_o      = bus_sel_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign bus_err_o      = err_q;
  assign if_rdata_o     = if_rdata_q;
  assign if_ack_o       = if_ack_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_ack_o      = mem_ack_q;
  assign stallreq_if_o  = if_req_i && !if_ack_q;
  assign stallreq_mem_o = mem_req_i && !mem_ack_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter with a small configurable slave model
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req_i = 1'b0, mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_wdata_i = '0;
  logic [3:0] mem_sel_i = '0;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic if_ack_o, mem_ack_o, bus_req_o, bus_we_o, bus_ack_i, bus_err_o, stallreq_if_o, stallreq_mem_o;
  logic [3:0] bus_sel_o;
  int n_checks = 0;
  int n_fail = 0;
  int req_age = 0;
  int slave_delay = 0;
  bit slave_on = 1'b0, stray_ack = 1'b0, use_fixed = 1'b0, last_data = 1'b0;
  logic [31:0] fixed_data = '0;
  always #5 clk = ~clk;
  always @(posedge clk) req_age <= bus_req_o ? req_age + 1 : 0;
  assign bus_ack_i   = (slave_on && bus_req_o && req_age >= slave_delay) || stray_ack;
  assign bus_rdata_i = use_fixed ? fixed_data : bus_addr_o ^ 32'h5A5A_0000;
  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic collide(input int exp_mem_c, input int exp_if_c);
    int mem_c = -1;
    int if_c = -1;
    if_addr_i = 32'h20; mem_addr_i = 32'h100; mem_we_i = 1'b0; mem_sel_i = 4'hF;
    if_req_i = 1'b1; mem_req_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (mem_ack_o) begin
        mem_c = c;
        check("coll_mem_rdata", mem_rdata_o, 32'h5A5A_0100);
      end
      if (if_ack_o) begin
        if_c = c;
        check("coll_if_rdata", if_rdata_o, 32'h5A5A_0020);
      end
      next_cycle();
      if (mem_c >= 0) mem_req_i = 1'b0;
      if (if_c >= 0) if_req_i = 1'b0;
    end
    check("coll_mem_cycle", mem_c, exp_mem_c);
    check("coll_if_cycle", if_c, exp_if_c);
  endtask
  initial begin
    int busy_n, acks, ack_c, err_c, if_acks, bad;
    bit first_data;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({bus_req_o, bus_we_o, if_ack_o, mem_ack_o, bus_err_o, bus_sel_o}), 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_wdata", bus_wdata_o, 0);
    check("rst_rdata", if_rdata_o | mem_rdata_o, 0);
    rst = 1'b0;
    next_cycle();
    // single fetch, slave acks in the first busy cycle
    use_fixed = 1'b1; fixed_data = 32'h3C01_0001; slave_on = 1'b1; slave_delay = 0;
    if_addr_i = 32'h10; if_req_i = 1'b1;
    @(negedge clk);
    check("f0_stall", 32'(stallreq_if_o), 1);
    check("f0_busreq", 32'(bus_req_o), 0);
    next_cycle(); @(negedge clk);
    check("f1_busreq", 32'(bus_req_o), 1);
    check("f1_addr", bus_addr_o, 32'h10);
    check("f1_we", 32'(bus_we_o), 0);
    check("f1_sel", 32'(bus_sel_o), 32'hF);
    check("f1_stall", 32'(stallreq_if_o), 1);
    next_cycle(); @(negedge clk);
    check("f2_busreq", 32'(bus_req_o), 0);
    check("f2_ack", 32'(if_ack_o), 0);
    check("f2_stall", 32'(stallreq_if_o), 1);
    next_cycle(); @(negedge clk);
    check("f3_ack", 32'(if_ack_o), 1);
    check("f3_rdata", if_rdata_o, 32'h3C01_0001);
    check("f3_stall", 32'(stallreq_if_o), 0);
    check("f3_memack", 32'(mem_ack_o), 0);
    next_cycle(); if_req_i = 1'b0; @(negedge clk);
    check("f4_ack", 32'(if_ack_o), 0);
    use_fixed = 1'b0;
    // write with a slave that acks on the third busy cycle
    next_cycle();
    mem_we_i = 1'b1; mem_sel_i = 4'b0011; mem_wdata_i = 32'hDEAD_BEEF; mem_addr_i = 32'h200;
    mem_req_i = 1'b1; slave_delay = 2;
    busy_n = 0; acks = 0; ack_c = -1; if_acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_req_o) begin
        busy_n++;
        check("w_we", 32'(bus_we_o), 1);
        check("w_addr", bus_addr_o, 32'h200);
        check("w_sel", 32'(bus_sel_o), 32'h3);
        check("w_wdata", bus_wdata_o, 32'hDEAD_BEEF);
      end
      if (mem_ack_o) begin
        acks++; ack_c = c;
        check("w_rdata", mem_rdata_o, 32'h5A5A_0200);
      end
      if (if_ack_o) if_acks++;
      next_cycle();
      if (acks > 0) mem_req_i = 1'b0;
    end
    check("w_busy_cycles", busy_n, 3);
    check("w_ack_count", acks, 1);
    check("w_ack_cycle", ack_c, 5);
    check("w_no_if_ack", if_acks, 0);
    check("w_if_rdata_kept", if_rdata_o, 32'h3C01_0001);
    mem_we_i = 1'b0; slave_delay = 0; last_data = 1'b1;
    // two collisions; expected order follows the arbitration policy
    for (int k = 0; k < 2; k++) begin
`ifdef STPU_ARB_RR_EN
      first_data = !last_data;
`else
      first_data = 1'b1;
`endif
      collide(first_data ? 3 : 7, first_data ? 7 : 3);
      last_data = !first_data;
    end
    // timeout: slave silent, watchdog of 4 busy cycles
    slave_on = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF; mem_req_i = 1'b1;
    busy_n = 0; ack_c = -1; err_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_req_o) busy_n++;
      if (bus_err_o) err_c = c;
      if (mem_ack_o) begin
        ack_c = c;
        check("to_rdata", mem_rdata_o, 0);
      end
      next_cycle();
      if (ack_c >= 0) mem_req_i = 1'b0;
    end
    check("to_busy_cycles", busy_n, 4);
    check("to_ack_cycle", ack_c, 6);
    check("to_err_cycle", err_c, 6);
    check("to_if_rdata_kept", if_rdata_o, 32'h5A5A_0020);
    // reset while the data transaction is busy, then a stray slave ack
    mem_addr_i = 32'h400; mem_req_i = 1'b1;
    next_cycle(); @(negedge clk);
    check("r_busy", 32'(bus_req_o), 1);
    #1 rst = 1'b1;
    #1;
    check("r_ctrl", 32'({bus_req_o, bus_we_o, if_ack_o, mem_ack_o, bus_err_o, bus_sel_o}), 0);
    check("r_addr", bus_addr_o, 0);
    check("r_rdata", if_rdata_o | mem_rdata_o, 0);
    mem_req_i = 1'b0;
    next_cycle();
    rst = 1'b0; stray_ack = 1'b1; bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_req_o || if_ack_o || mem_ack_o || bus_err_o) bad++;
      next_cycle();
    end
    check("r_stray_ignored", bad, 0);
    stray_ack = 1'b0;
    // a fresh fetch after reset still completes with normal latency
    slave_on = 1'b1; if_addr_i = 32'h40; if_req_i = 1'b1; ack_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_ack_o) begin
        ack_c = c;
        check("r_fetch_rdata", if_rdata_o, 32'h5A5A_0040);
      end
      next_cycle();
      if (ack_c >= 0) if_req_i = 1'b0;
    end
    check("r_fetch_cycle", ack_c, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (pc/if_id side) and the data port (mem stage).
- Latches each request and drives the slave bus until the slave acknowledges or a watchdog timeout fires.
- Returns read data with a one-cycle ack pulse to the requester.
- Raises per-port stall requests toward ctrl while a requester is waiting.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without bus_ack_i before the transaction is aborted. Legal range 1..255; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction, valid with if_ack_o
- if_ack_o  out  1  one-cycle completion pulse
- mem_req_i  in  1  data request, held until mem_ack_o
- mem_we_i  in  1  1 = write
- mem_addr_i  in  32  data address
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data, valid with mem_ack_o
- mem_ack_o  out  1  one-cycle completion pulse
- bus_req_o  out  1  slave request
- bus_we_o  out  1  slave write enable
- bus_addr_o  out  32  slave address
- bus_sel_o  out  4  slave byte enables
- bus_wdata_o  out  32  slave write data
- bus_rdata_i  in  32  slave read data
- bus_ack_i  in  1  slave completion, sampled only in BUSY
- bus_err_o  out  1  one-cycle pulse on timeout abort
- stallreq_if_o  out  1  if_req_i & ~if_ack_o
- stallreq_mem_o  out  1  mem_req_i & ~mem_ack_o

Behaviour:
- Reset (async): state IDLE, timeout counter 0, grant-last = IF. All registered outputs are 0: acks, bus_*_o, rdata, err.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Sample requests; pick the winner; latch its address, sel, we and wdata into the bus registers.
  - Next cycle: BUSY_x with bus_req_o = 1.
  - A fetch always drives we = 0 and sel = 4'b1111.
- BUSY_x:
  - bus_* outputs are held stable.
  - Timeout counter increments each cycle.
  - On bus_ack_i = 1: latch bus_rdata_i into the winner's rdata register; bus_req_o = 0 next cycle; go to RESP_x.
  - If the counter reaches TIMEOUT_CYCLES with no ack: bus_req_o = 0; rdata = 0; go to RESP_x with bus_err_o = 1 for that cycle.
- RESP_x:
  - x_ack_o = 1 for exactly one cycle, then IDLE.
  - The counter clears.
  - The other port's rdata register is unchanged.
- Latency: ack in the first BUSY cycle gives req-to-ack_o = 3 cycles. Back-to-back transactions are spaced 4 cycles apart (IDLE, BUSY, RESP, IDLE).
- Writes: mem_rdata_o takes the bus_rdata_i value at ack; the master ignores it.
- Requester dropping req mid-transaction: the bus transaction still completes and the ack pulse still issues; the master ignores it.
- bus_ack_i outside BUSY is ignored.
- Reset mid-transaction: return to IDLE immediately; a late slave ack is ignored.
- Stall outputs are combinational. They deassert in the RESP cycle so ctrl releases the pipeline on the same edge as data capture.
- Default arbitration: fixed priority, data over fetch. Simultaneous requests in IDLE grant data.

Optional Feature:
- Macro: STPU_ARB_RR_EN.
- Defined: round-robin. When both requests are present in IDLE, grant the port not served last; grant-last updates on each entry to RESP.
- Undefined: fixed data-over-fetch priority; the grant-last register is not synthesized.

Decomposition:
- Defines.vh additions:
  - Widths: RegBus, InstAddrBus.
  - State encodings: ArbIdle, ArbBusyI, ArbBusyD, ArbRespI, ArbRespD (3 bits).
  - ArbSelAll 4'b1111.
- Sub-module arb_timeout_cnt: 8-bit counter with clr, en and expired-flag output; instantiated once.

Test Plan:
- Single fetch: if_req_i = 1, addr 0x00000010; slave acks the first BUSY cycle with 0x3C010001 -> bus_addr_o = 0x10, bus_we_o = 0; if_ack_o pulses at cycle 3 with if_rdata_o = 0x3C010001; stallreq_if_o high cycles 0-2.
- Simultaneous requests, fixed priority: if_req_i and mem_req_i (addr 0x100, read) rise together -> data served first (mem_ack_o at cycle 3), fetch next (if_ack_o at cycle 7).
- Same stimulus with STPU_ARB_RR_EN after a prior data grant -> fetch served first; second collision alternates.
- Write: mem_we_i = 1, sel 4'b0011, wdata 0xDEADBEEF, addr 0x200 -> bus outputs match for all BUSY cycles; single mem_ack_o.
- Timeout: slave never acks, TIMEOUT_CYCLES = 4 -> bus_req_o high 4 cycles then low; bus_err_o and mem_ack_o pulse together; mem_rdata_o = 0.
- Reset in BUSY_D, then a stray bus_ack_i -> all outputs 0, no ack pulses; FSM stays IDLE.
